// File: rtl/vmask_pkg.sv
// Shared types and mask helpers for the vector mask feed stage.
// Optional macro VMASK_FEED_VSTART_EN enables the vstart head mask helper.
package vmask_pkg;

    localparam int unsigned MASK_MAX_W = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } vmask_state_e;

    function automatic int unsigned chunk_count(input int unsigned vl, input int unsigned w);
        return (vl + w - 1) / w;
    endfunction

    // n low bits set; n must not exceed MASK_MAX_W
    function automatic logic [MASK_MAX_W-1:0] low_ones(input int unsigned n);
        logic [MASK_MAX_W-1:0] ones;
        ones = '1;
        if (n == 0) begin
            return '0;
        end
        return ones >> (MASK_MAX_W - n);
    endfunction

    function automatic logic [MASK_MAX_W-1:0] tail_mask(input int unsigned k,
                                                         input int unsigned vl,
                                                         input int unsigned w);
        int unsigned lo;
        lo = k * w;
        if (vl <= lo) begin
            return '0;
        end
        if (vl - lo >= w) begin
            return low_ones(w);
        end
        return low_ones(vl - lo);
    endfunction

`ifdef VMASK_FEED_VSTART_EN
    // Bits at global positions >= vstart are kept
    function automatic logic [MASK_MAX_W-1:0] head_mask(input int unsigned k,
                                                         input int unsigned vstart,
                                                         input int unsigned w);
        int unsigned lo;
        lo = k * w;
        if (vstart <= lo) begin
            return low_ones(w);
        end
        if (vstart - lo >= w) begin
            return '0;
        end
        return low_ones(w) & ~low_ones(vstart - lo);
    endfunction
`endif

endpackage

// File: rtl/vmask_feed_gen.sv
// Combinational mask builder: applies v0, vl tail and (optionally) vstart head to one chunk.
// Optional macro VMASK_FEED_VSTART_EN adds the vstart input.
module vmask_gen
    import vmask_pkg::*;
#(
    parameter int unsigned W           = 64,
    parameter int unsigned VL_WIDTH    = 11,
    parameter int unsigned CHUNK_WIDTH = 6
) (
    input  logic [CHUNK_WIDTH-1:0] chunk,
    input  logic [VL_WIDTH-1:0]    vl,
    input  logic                   vm,
`ifdef VMASK_FEED_VSTART_EN
    input  logic [VL_WIDTH-1:0]    vstart,
`endif
    input  logic [W-1:0]           vs2,
    input  logic [W-1:0]           v0,
    output logic [W-1:0]           m0_c
);

    logic [W-1:0] tail;
    logic [W-1:0] head;
    logic [W-1:0] v0_sel;

    always_comb begin
        tail = W'(tail_mask(32'(chunk), 32'(vl), W));
`ifdef VMASK_FEED_VSTART_EN
        head = W'(head_mask(32'(chunk), 32'(vstart), W));
`else
        head = '1;
`endif
        v0_sel = vm ? '1 : v0;
        m0_c   = vs2 & v0_sel & tail & head;
    end

endmodule

// File: rtl/vmask_feed.sv
// Sequences vs2/v0 chunk reads and emits masked beats to the popcount stage.
// Optional macro VMASK_FEED_VSTART_EN adds in_vstart head masking.
module vmask_feed
    import vmask_pkg::*;
#(
    parameter  int unsigned REQ_DATA_WIDTH = 64,
    parameter  int unsigned REQ_ADDR_WIDTH = 32,
    parameter  int unsigned VL_WIDTH       = 11,
    localparam int unsigned CHUNK_WIDTH    = VL_WIDTH - $clog2(REQ_DATA_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_start,
    input  logic [VL_WIDTH-1:0]       in_vl,
    input  logic                      in_vm,
    input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
`ifdef VMASK_FEED_VSTART_EN
    input  logic [VL_WIDTH-1:0]       in_vstart,
`endif
    output logic                      rd_en,
    output logic [CHUNK_WIDTH-1:0]    rd_chunk,
    input  logic [REQ_DATA_WIDTH-1:0] rd_vs2,
    input  logic [REQ_DATA_WIDTH-1:0] rd_v0,
    output logic [REQ_DATA_WIDTH-1:0] out_m0,
    output logic                      out_valid,
    output logic                      out_end,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr,
    output logic                      busy
);

    localparam int unsigned W = REQ_DATA_WIDTH;

    vmask_state_e           state;
    vmask_state_e           state_d;
    logic                   accept;
    logic                   rd_en_d;
    logic [CHUNK_WIDTH-1:0] rd_chunk_d;
    logic                   iss_zero;
    logic                   iss_zero_d;
    logic [CHUNK_WIDTH-1:0] nchunks_d;
    logic [CHUNK_WIDTH-1:0] last_q;
    logic [VL_WIDTH-1:0]    vl_q;
    logic                   vm_q;
`ifdef VMASK_FEED_VSTART_EN
    logic [VL_WIDTH-1:0]    vstart_q;
`endif

    logic                   s1_valid;
    logic                   s1_end;
    logic                   s1_zero;
    logic [CHUNK_WIDTH-1:0] s1_chunk;
    logic [W-1:0]           m0_c;

    // Next-state and issue control
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        rd_en_d    = 1'b0;
        rd_chunk_d = rd_chunk;
        iss_zero_d = 1'b0;
        nchunks_d  = CHUNK_WIDTH'(chunk_count(32'(in_vl), W));
        unique case (state)
            IDLE: begin
                if (in_start) begin
                    accept     = 1'b1;
                    rd_chunk_d = '0;
                    if (in_vl != '0) begin
                        state_d = ISSUE;
                        rd_en_d = 1'b1;
                    end else begin
                        // vl==0 still owes downstream one zero beat
                        state_d    = DRAIN;
                        iss_zero_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rd_chunk == last_q) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d    = 1'b1;
                    rd_chunk_d = rd_chunk + CHUNK_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (out_valid && out_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, issue and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            rd_chunk <= '0;
            iss_zero <= 1'b0;
            busy     <= 1'b0;
            last_q   <= '0;
            vl_q     <= '0;
            vm_q     <= 1'b0;
            out_addr <= '0;
`ifdef VMASK_FEED_VSTART_EN
            vstart_q <= '0;
`endif
        end else begin
            state    <= state_d;
            rd_en    <= rd_en_d;
            rd_chunk <= rd_chunk_d;
            iss_zero <= iss_zero_d;
            busy     <= (state_d != IDLE);
            if (accept) begin
                last_q   <= nchunks_d - CHUNK_WIDTH'(1);
                vl_q     <= in_vl;
                vm_q     <= in_vm;
                out_addr <= in_addr;
`ifdef VMASK_FEED_VSTART_EN
                vstart_q <= in_vstart;
`endif
            end
        end
    end

    vmask_gen #(
        .W           (W),
        .VL_WIDTH    (VL_WIDTH),
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_gen (
        .chunk  (s1_chunk),
        .vl     (vl_q),
        .vm     (vm_q),
`ifdef VMASK_FEED_VSTART_EN
        .vstart (vstart_q),
`endif
        .vs2    (rd_vs2),
        .v0     (rd_v0),
        .m0_c   (m0_c)
    );

    // Two-stage beat pipeline aligned with the register-file read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_end    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_chunk  <= '0;
            out_valid <= 1'b0;
            out_end   <= 1'b0;
            out_m0    <= '0;
        end else begin
            s1_valid  <= rd_en | iss_zero;
            s1_end    <= iss_zero | (rd_en & (rd_chunk == last_q));
            s1_zero   <= iss_zero;
            s1_chunk  <= rd_chunk;
            out_valid <= s1_valid;
            out_end   <= s1_valid & s1_end;
            out_m0    <= (s1_valid && !s1_zero) ? m0_c : '0;
        end
    end

endmodule

// File: tb/tb_vmask_feed.sv
// Scoreboard bench for vmask_feed: register-file responder, beat/read monitors, directed and random commands.
module tb_vmask_feed;

    typedef struct packed {
        logic [63:0] m0;
        logic        endf;
        logic [31:0] addr;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_start;
    logic [10:0] in_vl;
    logic        in_vm;
    logic [31:0] in_addr;
`ifdef VMASK_FEED_VSTART_EN
    logic [10:0] in_vstart;
`endif
    logic        rd_en;
    logic [5:0]  rd_chunk;
    logic [63:0] rd_vs2;
    logic [63:0] rd_v0;
    logic [63:0] out_m0;
    logic        out_valid;
    logic        out_end;
    logic [31:0] out_addr;
    logic        busy;

    logic [63:0] vs2_mem [64];
    logic [63:0] v0_mem  [64];

    beat_t exp_q [$];
    int    rd_q  [$];
    int    n_checks;
    int    n_errors;
    int    n_end;
    bit    mon_en;

    vmask_feed dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_vl     (in_vl),
        .in_vm     (in_vm),
        .in_addr   (in_addr),
`ifdef VMASK_FEED_VSTART_EN
        .in_vstart (in_vstart),
`endif
        .rd_en     (rd_en),
        .rd_chunk  (rd_chunk),
        .rd_vs2    (rd_vs2),
        .rd_v0     (rd_v0),
        .out_m0    (out_m0),
        .out_valid (out_valid),
        .out_end   (out_end),
        .out_addr  (out_addr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_beat(input int k, input int vl, input bit vm,
                                               input logic [63:0] s, input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i] = ((k * 64 + i) < vl) && s[i] && (vm || v[i]);
        end
        return r;
    endfunction

    // Register file: data one cycle after rd_en, garbage otherwise
    always @(posedge clk) begin
        if (rd_en) begin
            rd_vs2 <= vs2_mem[rd_chunk];
            rd_v0  <= v0_mem[rd_chunk];
        end else begin
            rd_vs2 <= {$urandom, $urandom};
            rd_v0  <= {$urandom, $urandom};
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rd_en) begin
                check_eq("rd_q_nonempty", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) check_eq("rd_chunk", 64'(rd_chunk), 64'(rd_q.pop_front()));
            end
            if (out_valid) begin
                check_eq("beat_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_eq("out_m0", out_m0, b.m0);
                    check_eq("out_end", 64'(out_end), 64'(b.endf));
                    check_eq("out_addr", 64'(out_addr), 64'(b.addr));
                end
                if (out_end) n_end++;
            end else begin
                check_eq("idle_m0", out_m0, 64'd0);
            end
        end
    end

    task automatic start_cmd(input int vl, input bit vm, input logic [31:0] addr);
        int    nch;
        beat_t b;
        nch = (vl + 63) / 64;
        for (int k = 0; k < nch; k++) begin
            rd_q.push_back(k);
            b.m0   = model_beat(k, vl, vm, vs2_mem[k], v0_mem[k]);
            b.endf = (k == nch - 1);
            b.addr = addr;
            exp_q.push_back(b);
        end
        if (vl == 0) begin
            b.m0   = 64'd0;
            b.endf = 1'b1;
            b.addr = addr;
            exp_q.push_back(b);
        end
        in_vl    = 11'(vl);
        in_vm    = vm;
        in_addr  = addr;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic wait_end(input int exp_lat, input int cnt0);
        int cnt;
        cnt = cnt0;
        while (!(out_valid && out_end) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("end_latency", 64'(cnt), 64'(exp_lat));
        check_eq("busy_on_end", 64'(busy), 64'd1);
        @(negedge clk);
        check_eq("busy_fall", 64'(busy), 64'd0);
    endtask

    task automatic do_cmd(input int vl, input bit vm, input logic [31:0] addr);
        start_cmd(vl, vm, addr);
        wait_end((vl == 0) ? 3 : (vl + 63) / 64 + 2, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ends0;
        n_checks = 0;
        n_errors = 0;
        n_end    = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        in_start = 1'b0;
        in_vl    = '0;
        in_vm    = 1'b1;
        in_addr  = '0;
`ifdef VMASK_FEED_VSTART_EN
        in_vstart = '0;
`endif
        for (int i = 0; i < 64; i++) begin
            vs2_mem[i] = '0;
            v0_mem[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en", 64'(rd_en), 64'd0);
        check_eq("rst_rd_chunk", 64'(rd_chunk), 64'd0);
        check_eq("rst_out_m0", out_m0, 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_end", 64'(out_end), 64'd0);
        check_eq("rst_out_addr", 64'(out_addr), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Partial tail chunk
        for (int k = 0; k < 3; k++) vs2_mem[k] = '1;
        do_cmd(130, 1'b1, 32'h40);

        // Exact multiple of W, back-to-back on the cycle busy is low
        vs2_mem[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        do_cmd(64, 1'b1, 32'h44);

        // v0 masking
        vs2_mem[0] = '1;
        v0_mem[0]  = 64'h0000_0000_0000_F0FF;
        do_cmd(16, 1'b0, 32'h48);

        // vl==0: no read, one zero end beat
        do_cmd(0, 1'b1, 32'h4C);

        // Start while busy is ignored
        for (int k = 0; k < 4; k++) begin
            vs2_mem[k] = {$urandom, $urandom};
            v0_mem[k]  = {$urandom, $urandom};
        end
        ends0 = n_end;
        start_cmd(200, 1'b0, 32'h1234);
        in_start = 1'b1;
        in_vl    = 11'd8;
        in_vm    = 1'b1;
        in_addr  = 32'hDEAD;
        @(negedge clk);
        in_start = 1'b0;
        wait_end(6, 2);
        check_eq("single_end", 64'(n_end - ends0), 64'd1);
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
        do_cmd(8, 1'b1, 32'h88);

        // Reset mid-command after the 2nd beat
        for (int k = 0; k < 4; k++) vs2_mem[k] = '1;
        start_cmd(256, 1'b1, 32'h200);
        repeat (3) @(negedge clk);
        #1;
        exp_q.delete();
        rd_q.delete();
        ends0 = n_end;
        rst   = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_end", 64'(out_end), 64'd0);
        check_eq("mid_rst_m0", out_m0, 64'd0);
        check_eq("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_addr", 64'(out_addr), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_rst_no_end", 64'(n_end), 64'(ends0));
        vs2_mem[0] = '1;
        do_cmd(8, 1'b1, 32'h300);

        // Random commands
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 32; k++) begin
                vs2_mem[k] = {$urandom, $urandom};
                v0_mem[k]  = {$urandom, $urandom};
            end
            do_cmd(int'($urandom_range(1, 2047)), bit'($urandom_range(0, 1)), $urandom);
        end

        repeat (3) @(negedge clk);
        check_eq("final_exp_q", 64'(exp_q.size()), 64'd0);
        check_eq("final_rd_q", 64'(rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
